// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: 8N1 UART transmitter fed from a small circular FIFO.
// Byte-wide valid/ready input, registered serial output idling high.
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN
// is defined (8E1, 11-bit frames); default build is plain 8N1.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | line high, waiting for the FIFO to hold a byte
// START  | start bit (low) for CLKS_PER_BIT cycles
// DATA   | 8 data bits LSB first, CLKS_PER_BIT cycles each
// PARITY | even parity of the data byte (only with UART_TX_PARITY_EN)
// STOP   | stop bit (high); chains straight into START if FIFO non-empty

module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_AW      = 2
) (
    input  logic               CLK,
    input  logic               rst,
    input  logic [7:0]         tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic               tx_out,
    output logic               tx_busy,
    output logic [FIFO_AW:0]   fifo_level
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] LEVEL_FULL = (FIFO_AW + 1)'(DEPTH);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [7:0]         head;
    logic               push;
    logic               pop;

    logic [BW-1:0]      baud_cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         shift_reg;
    logic               bit_done;
    logic               line_d;
`ifdef UART_TX_PARITY_EN
    logic               parity_bit;
`endif

    // Ready depends only on the registered level, so a same-cycle pop never frees a slot early.
    assign tx_ready = (fifo_level != LEVEL_FULL);
    assign push     = tx_valid && tx_ready;
    assign head     = mem[rd_ptr];
    assign bit_done = (baud_cnt == BAUD_LAST);
    assign tx_busy  = (state_q != IDLE) || (fifo_level != '0);

    // FIFO storage; contents need no reset because level gates every read.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge CLK) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; pops only when leaving IDLE or chaining out of STOP.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (fifo_level != '0) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_done && (bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    if (fifo_level != '0) begin
                        pop     = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line level for the current state; registered into tx_out below.
    always_comb begin
        line_d = 1'b1;
        case (state_q)
            IDLE:    line_d = 1'b1;
            START:   line_d = 1'b0;
            DATA:    line_d = shift_reg[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  line_d = parity_bit;
`endif
            STOP:    line_d = 1'b1;
            default: line_d = 1'b1;
        endcase
    end

    // Baud timing, bit index and data shift register.
    always_ff @(posedge CLK) begin
        if (rst) begin
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else if (pop) begin
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= head;
        end else if (state_q == IDLE) begin
            baud_cnt <= '0;
        end else if (bit_done) begin
            baud_cnt <= '0;
            if (state_q == DATA) begin
                shift_reg <= shift_reg >> 1;
                bit_idx   <= bit_idx + 1'b1;
            end
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Even parity captured alongside the byte at pop time.
    always_ff @(posedge CLK) begin
        if (rst) begin
            parity_bit <= 1'b0;
        end else if (pop) begin
            parity_bit <= ^head;
        end
    end
`endif

    // Registered serial output; reset forces the line high on the next edge.
    always_ff @(posedge CLK) begin
        if (rst) begin
            tx_out <= 1'b1;
        end else begin
            tx_out <= line_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: scoreboard bench for uart_tx_buffered.
// Accepted bytes are queued as expected frames; a line monitor decodes the
// serial output independently and compares against the queue.

module tb_uart_tx_buffered;

    localparam int CPB   = 4;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic          CLK = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    tx_data = 8'h00;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic          tx_out;
    logic          tx_busy;
    logic [AW:0]   fifo_level;

    int            n_tests = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            frames_seen = 0;
    logic [7:0]    exp_q[$];
    int            frame_starts[$];

    uart_tx_buffered #(
        .CLKS_PER_BIT(CPB),
        .FIFO_AW(AW)
    ) dut (
        .CLK(CLK),
        .rst(rst),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_out(tx_out),
        .tx_busy(tx_busy),
        .fifo_level(fifo_level)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Offer one byte; keep=1 leaves tx_valid high for a following push.
    task automatic push_byte(input logic [7:0] b, input bit keep, output int stalled);
        int prev_level;
        stalled  = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        forever begin
            @(negedge CLK);
            if (tx_ready) break;
            if (stalled == 0) check("full_level_at_stall", int'(fifo_level), DEPTH);
            stalled++;
            if (stalled > 2000) begin
                check("push_timeout", 1, 0);
                tx_valid = 1'b0;
                return;
            end
        end
        prev_level = int'(fifo_level);
        @(posedge CLK);
        exp_q.push_back(b);
        #1;
        if (!keep) tx_valid = 1'b0;
        if (stalled > 0) begin
            // The pop that freed the slot must not have admitted a push itself.
            check("no_bypass_level_before", prev_level, DEPTH - 1);
            check("refill_level", int'(fifo_level), DEPTH);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        forever begin
            @(negedge CLK);
            if (!tx_busy) break;
            n++;
            if (n > 5000) begin
                check("idle_timeout", 1, 0);
                break;
            end
        end
        tick(3);
    endtask

    task automatic check_gaps(input int first);
        for (int k = first; k + 1 < frame_starts.size(); k++) begin
            check("back_to_back_spacing", frame_starts[k + 1] - frame_starts[k], FRAME);
        end
    endtask

    // Line monitor: decode every frame from the serial pin alone.
    logic [FRAME-1:0] line_v;
    initial begin : monitor
        int   bad;
        bit   aborted;
        logic [7:0] got;
        logic [7:0] exp;
        forever begin
            @(negedge CLK);
            if (rst || tx_out !== 1'b0) continue;
            frame_starts.push_back(cyc);
            line_v    = '0;
            line_v[0] = 1'b0;
            aborted   = 1'b0;
            for (int i = 1; i < FRAME; i++) begin
                @(negedge CLK);
                if (rst) begin
                    aborted = 1'b1;
                    break;
                end
                line_v[i] = tx_out;
            end
            if (aborted) continue;
            bad = 0;
            for (int k = 0; k < NBITS; k++)
                for (int c = 1; c < CPB; c++)
                    if (line_v[k * CPB + c] !== line_v[k * CPB]) bad++;
            check("bit_width", bad, 0);
            for (int j = 0; j < 8; j++) got[j] = line_v[(1 + j) * CPB];
            check("stop_bit", int'(line_v[(NBITS - 1) * CPB]), 1);
            frames_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_frame", int'(got), -1);
            end else begin
                exp = exp_q.pop_front();
                check("frame_byte", int'(got), int'(exp));
`ifdef UART_TX_PARITY_EN
                check("parity_bit", int'(line_v[9 * CPB]), int'(^exp));
`endif
            end
        end
    end

    initial begin : stim
        int st;
        int stalls[6];
        int first;
        int n;
        int lows;
        int seen_before;

        // Reset state
        tick(3);
        check("rst_tx_out", int'(tx_out), 1);
        check("rst_tx_ready", int'(tx_ready), 1);
        check("rst_tx_busy", int'(tx_busy), 0);
        check("rst_fifo_level", int'(fifo_level), 0);
        rst = 1'b0;
        tick(2);

        // Single byte 0xA5: handshake latency and busy window
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(posedge CLK);                       // edge N: push
        exp_q.push_back(8'hA5);
        #1;
        tx_valid = 1'b0;
        check("lat_level_after_push", int'(fifo_level), 1);
        check("lat_busy_after_push", int'(tx_busy), 1);
        check("lat_line_edge_n", int'(tx_out), 1);
        tick(1);                              // edge N+1: pop, FSM enters START
        check("lat_level_after_pop", int'(fifo_level), 0);
        check("lat_line_edge_n1", int'(tx_out), 1);
        tick(1);                              // edge N+2: registered line falls
        check("lat_line_falls", int'(tx_out), 0);
        // FSM returns to IDLE 40 cycles after entering START (edge N+41).
        tick(38);
        check("busy_before_frame_end", int'(tx_busy), 1);
        tick(1);
        check("busy_after_frame_end", int'(tx_busy), 0);
        check("line_in_last_stop_cycle", int'(tx_out), 1);
        wait_idle();

        // Held tx_valid with 0x01..0x06: fills, stalls, then chains frames
        first = frame_starts.size();
        for (int i = 0; i < 6; i++) begin
            push_byte(8'(i + 1), (i < 5), st);
            stalls[i] = st;
        end
        check("sixth_byte_stalled", int'(stalls[5] > 0), 1);
        wait_idle();
        check("hold_frame_count", frame_starts.size() - first, 6);
        check_gaps(first);

        // 0x00 then 0xFF back-to-back
        first = frame_starts.size();
        push_byte(8'h00, 1'b1, st);
        push_byte(8'hFF, 1'b0, st);
        wait_idle();
        check_gaps(first);

`ifdef UART_TX_PARITY_EN
        // Parity frame for 0x07
        push_byte(8'h07, 1'b0, st);
        wait_idle();
`endif

        // Reset at data bit 3 of 0x55 with two more bytes queued
        push_byte(8'h55, 1'b1, st);
        push_byte(8'hAA, 1'b1, st);
        push_byte(8'h33, 1'b0, st);
        check("queued_before_reset", int'(fifo_level), 2);
        n = 0;
        forever begin
            @(negedge CLK);
            if (tx_out === 1'b0) break;
            n++;
            if (n > 200) begin
                check("start_timeout", 1, 0);
                break;
            end
        end
        // Line cycle index 16 is the first cycle of data bit 3.
        repeat (16) @(posedge CLK);
        #1;
        seen_before = frames_seen;
        rst = 1'b1;
        exp_q.delete();
        tick(1);
        rst = 1'b0;
        check("abort_tx_out", int'(tx_out), 1);
        check("abort_level", int'(fifo_level), 0);
        check("abort_ready", int'(tx_ready), 1);
        check("abort_busy", int'(tx_busy), 0);
        lows = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge CLK);
            if (tx_out !== 1'b1) lows++;
        end
        check("no_frames_after_reset", lows, 0);
        check("aborted_frame_not_counted", frames_seen, seen_before);
        tick(1);

        // Randomized traffic with random idle gaps
        for (int i = 0; i < 40; i++) begin
            push_byte(8'($urandom_range(0, 255)), 1'b0, st);
            if ($urandom_range(0, 3) != 0) tick($urandom_range(0, 60));
        end
        wait_idle();
        check("scoreboard_drained", exp_q.size(), 0);
        check("final_level", int'(fifo_level), 0);
        check("final_line_idle", int'(tx_out), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

endmodule
